mux_err_monitor: RTL and testbench

MUX_ERR_MONITOR -- requirements
Module: mux_err_monitor

---
 rtl/mux_err_monitor.sv | 138 +++++++++++++
 tb/tb_mux_err_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_err_monitor.sv
// Mux error monitor: per-path saturating error counters, consecutive-error run
// tracking, first-failure capture and a sticky alarm driven by a small FSM.
module mux_err_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_MAX = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           sample,
  input  logic                           err,
  input  logic                           sel,
  input  logic [CNT_W-1:0]               thresh,
  output logic [CNT_W-1:0]               cnt_a,
  output logic [CNT_W-1:0]               cnt_b,
  output logic [CNT_W:0]                 cnt_tot,
  output logic [$clog2(RUN_MAX+1)-1:0]   run_len,
  output logic                           first_vld,
  output logic                           first_sel,
  output logic                           alarm,
  output logic [1:0]                     state
);

  localparam int RL_W = $clog2(RUN_MAX + 1);
  localparam logic [RL_W-1:0]  RUN_LIM = RL_W'(RUN_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [RL_W-1:0]  r_run;
  logic             r_first_vld;
  logic             r_first_sel;

  logic             w_smp;
  logic             w_err_a;
  logic             w_err_b;
  logic [CNT_W-1:0] w_cnt_a_nxt;
  logic [CNT_W-1:0] w_cnt_b_nxt;
  logic [CNT_W:0]   w_tot_nxt;
  logic [RL_W-1:0]  w_run_nxt;
  logic             w_run_trip;
  logic             w_thr_trip;
  logic             w_trip;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [RL_W-1:0] sat_inc_run(input logic [RL_W-1:0] v);
    return (v >= RUN_LIM) ? RUN_LIM : v + RL_W'(1);
  endfunction

  // A sample only counts while armed; a concurrent clr discards it.
  assign w_smp   = sample & (r_state == ST_ARMED) & ~clr;
  assign w_err_a = w_smp & err & sel;
  assign w_err_b = w_smp & err & ~sel;

  assign w_cnt_a_nxt = w_err_a ? sat_inc_cnt(r_cnt_a) : r_cnt_a;
  assign w_cnt_b_nxt = w_err_b ? sat_inc_cnt(r_cnt_b) : r_cnt_b;
  assign w_tot_nxt   = {1'b0, w_cnt_a_nxt} + {1'b0, w_cnt_b_nxt};

  always_comb begin
    w_run_nxt = r_run;
    if (w_smp) begin
      w_run_nxt = err ? sat_inc_run(r_run) : '0;
    end
  end

  // Trip is judged on the post-update values so the alarm lands with the counts.
  assign w_run_trip = err & (w_run_nxt == RUN_LIM);
  assign w_thr_trip = (thresh != '0) & (w_tot_nxt >= {1'b0, thresh});
  assign w_trip     = w_smp & (w_run_trip | w_thr_trip);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (w_trip)   w_state_nxt = ST_ALARM;
        else if (!en) w_state_nxt = ST_IDLE;
      end
      ST_ALARM: w_state_nxt = ST_ALARM;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (clr) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    state = r_state;
    alarm = (r_state == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
      r_run       <= '0;
      r_first_vld <= 1'b0;
      r_first_sel <= 1'b0;
    end else begin
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_run   <= w_run_nxt;
      if (w_smp && err && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_sel <= sel;
      end
    end
  end

  assign cnt_a     = r_cnt_a;
  assign cnt_b     = r_cnt_b;
  assign cnt_tot   = {1'b0, r_cnt_a} + {1'b0, r_cnt_b};
  assign run_len   = r_run;
  assign first_vld = r_first_vld;
  assign first_sel = r_first_sel;

endmodule

// File: tb/tb_mux_err_monitor.sv
// Bench for mux_err_monitor: directed scenarios plus randomized traffic
// compared each cycle against a behavioural model of the monitor.
module tb_mux_err_monitor;

  localparam int CNT_W   = 8;
  localparam int RUN_MAX = 4;
  localparam int RL_W    = $clog2(RUN_MAX + 1);
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic             sample = 1'b0;
  logic             err = 1'b0;
  logic             sel = 1'b0;
  logic [CNT_W-1:0] thresh = '0;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic [CNT_W:0]   cnt_tot;
  logic [RL_W-1:0]  run_len;
  logic             first_vld;
  logic             first_sel;
  logic             alarm;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_err = 0;

  // model state: 0 idle, 1 armed, 2 alarm
  int m_a, m_b, m_run, m_fv, m_fs, m_state;

  mux_err_monitor #(.CNT_W(CNT_W), .RUN_MAX(RUN_MAX)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .sample(sample), .err(err),
    .sel(sel), .thresh(thresh), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .cnt_tot(cnt_tot), .run_len(run_len), .first_vld(first_vld),
    .first_sel(first_sel), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic m_update(input bit a_rst, a_clr, a_en, a_smp, a_err, a_sel, input int thr);
    bit trip;
    trip = 1'b0;
    if (a_rst || a_clr) begin
      m_a = 0; m_b = 0; m_run = 0; m_fv = 0; m_fs = 0; m_state = 0;
    end else if (m_state == 0) begin
      if (a_en) m_state = 1;
    end else if (m_state == 1) begin
      if (a_smp) begin
        if (a_err) begin
          if (a_sel) m_a = (m_a < CMAX) ? m_a + 1 : m_a;
          else       m_b = (m_b < CMAX) ? m_b + 1 : m_b;
          m_run = (m_run < RUN_MAX) ? m_run + 1 : RUN_MAX;
          if (m_fv == 0) begin
            m_fv = 1;
            m_fs = a_sel;
          end
          if (m_run == RUN_MAX) trip = 1'b1;
        end else begin
          m_run = 0;
        end
        if (thr != 0 && (m_a + m_b) >= thr) trip = 1'b1;
      end
      if (trip)       m_state = 2;
      else if (!a_en) m_state = 0;
    end
  endtask

  task automatic chk_model();
    chk("cnt_a", 32'(cnt_a), 32'(m_a));
    chk("cnt_b", 32'(cnt_b), 32'(m_b));
    chk("cnt_tot", 32'(cnt_tot), 32'(m_a + m_b));
    chk("run_len", 32'(run_len), 32'(m_run));
    chk("first_vld", 32'(first_vld), 32'(m_fv));
    chk("first_sel", 32'(first_sel), 32'(m_fv != 0 ? m_fs : 0));
    chk("alarm", 32'(alarm), 32'(m_state == 2));
    chk("state", 32'(state), 32'(m_state));
  endtask

  task automatic step(input bit a_rst, a_clr, a_en, a_smp, a_err, a_sel);
    rst = a_rst; clr = a_clr; en = a_en; sample = a_smp; err = a_err; sel = a_sel;
    @(posedge clk);
    m_update(a_rst, a_clr, a_en, a_smp, a_err, a_sel, int'(thresh));
    #1;
    chk_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cnt_tot"}, 32'(cnt_tot), 0);
    chk({tag, "_run"}, 32'(run_len), 0);
    chk({tag, "_fvld"}, 32'(first_vld), 0);
    chk({tag, "_alarm"}, 32'(alarm), 0);
    chk({tag, "_state"}, 32'(state), 0);
  endtask

  initial begin
    bit r_e, r_s, r_er, r_sl, r_c, r_r;

    // reset state
    thresh = '0;
    step(1, 0, 0, 0, 0, 0);
    chk_all_zero("rst");

    // three errors on path a
    step(0, 0, 1, 0, 0, 0);
    chk("arm_state", 32'(state), 1);
    repeat (3) step(0, 0, 1, 1, 1, 1);
    chk("s1_cnt_a", 32'(cnt_a), 3);
    chk("s1_cnt_b", 32'(cnt_b), 0);
    chk("s1_run", 32'(run_len), 3);
    chk("s1_alarm", 32'(alarm), 0);
    chk("s1_fsel", 32'(first_sel), 1);

    // run-length trip with alternating sel starting at 0
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, bit'(i % 2));
    chk("s2_pre_alarm", 32'(alarm), 0);
    step(0, 0, 1, 1, 1, 1);
    chk("s2_alarm", 32'(alarm), 1);
    chk("s2_state", 32'(state), 2);
    chk("s2_fsel", 32'(first_sel), 0);
    chk("s2_cnt_a", 32'(cnt_a), 2);
    chk("s2_cnt_b", 32'(cnt_b), 2);
    // alarm ignores en and further samples
    step(0, 0, 0, 1, 1, 1);
    chk("s2_sticky", 32'(alarm), 1);
    chk("s2_hold_a", 32'(cnt_a), 2);
    // clr with a simultaneous error sample
    step(0, 1, 1, 1, 1, 1);
    chk_all_zero("clr");
    chk("clr_cnt_a", 32'(cnt_a), 0);

    // threshold trip with err=0 spacers
    step(1, 0, 0, 0, 0, 0);
    thresh = 8'd5;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 1, bit'(i % 3 != 2), bit'(i % 2));
    chk("s3_pre_alarm", 32'(alarm), 0);
    step(0, 0, 1, 1, 1, 0);
    chk("s3_alarm", 32'(alarm), 1);
    chk("s3_tot", 32'(cnt_tot), 5);

    // threshold lowered without a sample must not trip until the next sample
    step(1, 0, 0, 0, 0, 0);
    thresh = 8'd0;
    step(0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    thresh = 8'd2;
    step(0, 0, 1, 0, 0, 0);
    chk("thr_no_retro", 32'(state), 1);
    step(0, 0, 1, 1, 0, 0);
    chk("thr_next_smp", 32'(state), 2);

    // saturation of cnt_b
    step(1, 0, 0, 0, 0, 0);
    thresh = 8'd0;
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 1, 0, 0);
    end
    chk("sat_cnt_b", 32'(cnt_b), 255);
    chk("sat_tot", 32'(cnt_tot), 255);
    chk("sat_state", 32'(state), 1);

    // samples in idle are ignored; reset mid-run discards history
    step(1, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 1, 1, 1);
    chk("idle_cnt_a", 32'(cnt_a), 0);
    chk("idle_state", 32'(state), 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 1, 1, 1, 1);
    chk("mid_cnt_a", 32'(cnt_a), 2);
    step(1, 0, 1, 1, 1, 1);
    chk_all_zero("midrst");
    chk("midrst_cnt_a", 32'(cnt_a), 0);
    step(0, 0, 0, 1, 1, 1);
    chk("rearm_needed", 32'(state), 0);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0)
        thresh = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      r_r  = ($urandom_range(0, 99) == 0);
      r_c  = ($urandom_range(0, 39) == 0);
      r_e  = ($urandom_range(0, 9) != 0);
      r_s  = $urandom_range(0, 1) != 0;
      r_er = ($urandom_range(0, 9) < 6);
      r_sl = $urandom_range(0, 1) != 0;
      step(r_r, r_c, r_e, r_s, r_er, r_sl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
